// File: rtl/pc_sequencer.sv
// Program-counter / control-flow sequencer driving a small return-address stack.
// Optional PC_SEQ_FAULT_VECTOR_EN: stack over/underflow redirects to FAULT_VECTOR instead of stopping.
module pc_sequencer #(
  parameter int unsigned         PC_WIDTH     = 9,
  parameter int unsigned         STACK_DEPTH  = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [PC_WIDTH-1:0] FAULT_VECTOR = 9'h1F0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                halt,
  input  logic                resume,
  input  logic                jmp,
  input  logic                br_taken,
  input  logic                call,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] target,
  input  logic [PC_WIDTH-1:0] stack_top,
  output logic                stack_push,
  output logic                stack_pop,
  output logic [PC_WIDTH-1:0] stack_in,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pc_valid,
  output logic [1:0]          depth,
  output logic                fault
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt, StFault} state_e;

  localparam logic [1:0] DepthMax = 2'(STACK_DEPTH);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]          depth_q, depth_d;
  logic                fault_q, fault_d;
  logic                stack_err;
  logic [PC_WIDTH-1:0] pc_inc;

  assign pc_inc   = pc_q + PC_WIDTH'(1);
  assign stack_in = pc_inc;
  assign pc       = pc_q;
  assign depth    = depth_q;
  assign fault    = fault_q;
  assign pc_valid = (state_q == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      depth_q <= 2'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    depth_d    = depth_q;
    fault_d    = fault_q;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    stack_err  = 1'b0;

    case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        if (!stall) begin
          if (halt) begin
            state_d = StHalt;
          end else if (ret) begin
            // ret outranks call; a simultaneous call is dropped entirely.
            if (depth_q == 2'd0) begin
              stack_err = 1'b1;
            end else begin
              pc_d      = stack_top;
              stack_pop = 1'b1;
              depth_d   = depth_q - 2'd1;
            end
          end else if (call) begin
            if (depth_q == DepthMax) begin
              stack_err = 1'b1;
            end else begin
              pc_d       = target;
              stack_push = 1'b1;
              depth_d    = depth_q + 2'd1;
            end
          end else if (jmp || br_taken) begin
            pc_d = target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      StHalt: begin
        if (!stall && resume) state_d = StRun;
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase

    // Offending push/pop is already suppressed above; only the recovery differs.
    if (stack_err) begin
      fault_d = 1'b1;
`ifdef PC_SEQ_FAULT_VECTOR_EN
      pc_d    = FAULT_VECTOR;
      depth_d = 2'd0;
`else
      state_d = StFault;
`endif
    end
  end

`ifndef PC_SEQ_FAULT_VECTOR_EN
  logic [PC_WIDTH-1:0] unused_fault_vector;
  assign unused_fault_vector = FAULT_VECTOR;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed per-cycle vectors, expected outputs queued and
// compared by a negedge monitor.
module tb_pc_sequencer;

  localparam logic [6:0] CNone   = 7'b0000000;
  localparam logic [6:0] CStall  = 7'b1000000;
  localparam logic [6:0] CHalt   = 7'b0100000;
  localparam logic [6:0] CResume = 7'b0010000;
  localparam logic [6:0] CJmp    = 7'b0001000;
  localparam logic [6:0] CBr     = 7'b0000100;
  localparam logic [6:0] CCall   = 7'b0000010;
  localparam logic [6:0] CRet    = 7'b0000001;

  logic       clk, rst_n;
  logic       stall, halt, resume, jmp, br_taken, call, ret;
  logic [8:0] target, stack_top;
  logic       stack_push, stack_pop, pc_valid, fault;
  logic [8:0] stack_in, pc;
  logic [1:0] depth;

  typedef struct {
    string      name;
    logic [8:0] pc;
    logic       valid;
    logic [1:0] depth;
    logic       fault;
    logic       push;
    logic       pop;
    logic [8:0] sin;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .halt       (halt),
    .resume     (resume),
    .jmp        (jmp),
    .br_taken   (br_taken),
    .call       (call),
    .ret        (ret),
    .target     (target),
    .stack_top  (stack_top),
    .stack_push (stack_push),
    .stack_pop  (stack_pop),
    .stack_in   (stack_in),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .depth      (depth),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: the DUT presents outputs every cycle, so compare mid-cycle whenever a vector is queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (pc !== mon_e.pc || pc_valid !== mon_e.valid || depth !== mon_e.depth ||
          fault !== mon_e.fault || stack_push !== mon_e.push || stack_pop !== mon_e.pop ||
          (mon_e.push && stack_in !== mon_e.sin)) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b d=%0d f=%b push=%b pop=%b sin=%h, want pc=%h v=%b d=%0d f=%b push=%b pop=%b sin=%h",
                 mon_e.name, pc, pc_valid, depth, fault, stack_push, stack_pop, stack_in,
                 mon_e.pc, mon_e.valid, mon_e.depth, mon_e.fault, mon_e.push, mon_e.pop,
                 mon_e.sin);
      end
    end
  end

  task automatic step(input string name, input logic [6:0] ctl, input logic [8:0] tgt,
                      input logic [8:0] top, input logic [8:0] epc, input logic ev,
                      input logic [1:0] ed, input logic ef, input logic ep, input logic eo,
                      input logic [8:0] es);
    exp_t e;
    {stall, halt, resume, jmp, br_taken, call, ret} = ctl;
    target    = tgt;
    stack_top = top;
    e.name = name; e.pc = epc; e.valid = ev; e.depth = ed; e.fault = ef;
    e.push = ep;   e.pop = eo; e.sin = es;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {stall, halt, resume, jmp, br_taken, call, ret} = CNone;
    target = '0;
    stack_top = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    step("idle",       CNone,       9'h000, 9'h000, 9'h000, 0, 0, 0, 0, 0, 9'h000);
    step("run0",       CNone,       9'h000, 9'h000, 9'h000, 1, 0, 0, 0, 0, 9'h000);
    step("run1",       CNone,       9'h000, 9'h000, 9'h001, 1, 0, 0, 0, 0, 9'h000);
    step("run2",       CNone,       9'h000, 9'h000, 9'h002, 1, 0, 0, 0, 0, 9'h000);
    step("jmp",        CJmp,        9'h010, 9'h000, 9'h003, 1, 0, 0, 0, 0, 9'h000);
    step("call",       CCall,       9'h080, 9'h000, 9'h010, 1, 0, 0, 1, 0, 9'h011);
    step("ret",        CRet,        9'h000, 9'h011, 9'h080, 1, 1, 0, 0, 1, 9'h000);
    step("after_ret",  CNone,       9'h000, 9'h000, 9'h011, 1, 0, 0, 0, 0, 9'h000);
    step("stall_call", CStall|CCall, 9'h100, 9'h000, 9'h012, 1, 0, 0, 0, 0, 9'h000);
    step("br",         CBr,         9'h1FF, 9'h000, 9'h012, 1, 0, 0, 0, 0, 9'h000);
    step("at_1ff",     CNone,       9'h000, 9'h000, 9'h1FF, 1, 0, 0, 0, 0, 9'h000);
    step("wrapped",    CJmp,        9'h1FF, 9'h000, 9'h000, 1, 0, 0, 0, 0, 9'h000);
    step("call_wrap",  CCall,       9'h020, 9'h000, 9'h1FF, 1, 0, 0, 1, 0, 9'h000);
    step("call2",      CCall,       9'h040, 9'h000, 9'h020, 1, 1, 0, 1, 0, 9'h021);
    step("ret2",       CRet,        9'h000, 9'h021, 9'h040, 1, 2, 0, 0, 1, 9'h000);
    step("call_ret",   CCall|CRet,  9'h0AA, 9'h000, 9'h021, 1, 1, 0, 0, 1, 9'h000);
    step("halt",       CHalt|CJmp,  9'h155, 9'h000, 9'h000, 1, 0, 0, 0, 0, 9'h000);
    step("halted",     CNone,       9'h000, 9'h000, 9'h000, 0, 0, 0, 0, 0, 9'h000);
    step("resume",     CResume,     9'h000, 9'h000, 9'h000, 0, 0, 0, 0, 0, 9'h000);
    step("resumed",    CNone,       9'h000, 9'h000, 9'h000, 1, 0, 0, 0, 0, 9'h000);
    step("call_a",     CCall,       9'h030, 9'h000, 9'h001, 1, 0, 0, 1, 0, 9'h002);
    step("call_b",     CCall,       9'h050, 9'h000, 9'h030, 1, 1, 0, 1, 0, 9'h031);
    step("overflow",   CCall,       9'h070, 9'h000, 9'h050, 1, 2, 0, 0, 0, 9'h000);
`ifdef PC_SEQ_FAULT_VECTOR_EN
    step("post_ovf",   CNone,       9'h000, 9'h000, 9'h1F0, 1, 0, 1, 0, 0, 9'h000);
    step("post_ovf2",  CNone,       9'h000, 9'h000, 9'h1F1, 1, 0, 1, 0, 0, 9'h000);
`else
    step("post_ovf",   CNone,       9'h000, 9'h000, 9'h050, 0, 2, 1, 0, 0, 9'h000);
    step("post_ovf2",  CCall|CJmp,  9'h0AA, 9'h000, 9'h050, 0, 2, 1, 0, 0, 9'h000);
`endif

    // Asynchronous reset mid-cycle must take effect without a clock edge.
    #2 rst_n = 1'b0;
    {stall, halt, resume, jmp, br_taken, call, ret} = CNone;
    #1;
    checks++;
    if (pc !== 9'h000 || pc_valid !== 1'b0 || fault !== 1'b0 || depth !== 2'd0 ||
        stack_push !== 1'b0 || stack_pop !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got pc=%h v=%b f=%b d=%0d push=%b pop=%b, want pc=000 v=0 f=0 d=0 push=0 pop=0",
               pc, pc_valid, fault, depth, stack_push, stack_pop);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    step("idle2",      CNone,       9'h000, 9'h000, 9'h000, 0, 0, 0, 0, 0, 9'h000);
    step("underflow",  CRet,        9'h000, 9'h123, 9'h000, 1, 0, 0, 0, 0, 9'h000);
`ifdef PC_SEQ_FAULT_VECTOR_EN
    step("post_unf",   CNone,       9'h000, 9'h000, 9'h1F0, 1, 0, 1, 0, 0, 9'h000);
`else
    step("post_unf",   CNone,       9'h000, 9'h000, 9'h000, 0, 0, 1, 0, 0, 9'h000);
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and control-flow sequencer for the mini CPU; sits directly upstream of the 2-entry return-address stack.
- Generates the 9-bit fetch PC each cycle and resolves sequential, jump, branch, call and return flow.
- Drives the stack's push/pop/in and consumes its top-of-stack output.
- Stack has no occupancy tracking, so this block tracks depth and flags overflow/underflow.

Parameters:
- PC_WIDTH, 9, width of PC, target and stack data.
- STACK_DEPTH, 2, capacity of the downstream return stack.
- RESET_PC, 0, PC value loaded on reset.
- FAULT_VECTOR, 9'h1F0, fault handler address; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freeze PC and all control actions this cycle.
- halt  in  1  enter HALT at next edge.
- resume  in  1  leave HALT back to RUN.
- jmp  in  1  unconditional jump to target.
- br_taken  in  1  conditional branch resolved taken; jump to target.
- call  in  1  call target; push return address.
- ret  in  1  return to stack_top; pop.
- target  in  PC_WIDTH  jump/branch/call destination.
- stack_top  in  PC_WIDTH  from stack output (current top entry).
- stack_push  out  1  to stack push.
- stack_pop  out  1  to stack pop.
- stack_in  out  PC_WIDTH  to stack in; return address.
- pc  out  PC_WIDTH  current fetch address (registered).
- pc_valid  out  1  pc is a valid fetch this cycle.
- depth  out  2  live stack entries, 0..STACK_DEPTH.
- fault  out  1  sticky stack over/underflow flag.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, depth=0, fault=0, state=IDLE.
  - pc_valid=0, stack_push=0, stack_pop=0.
  - Stack contents are not reset; depth=0 makes them don't-care.
- States:
  - IDLE: one cycle after reset release, pc_valid=0, then RUN.
  - RUN: pc_valid=1.
  - HALT: pc held, pc_valid=0.
  - FAULT: pc held, pc_valid=0, fault=1.
- IDLE->RUN unconditionally.
- RUN->HALT when halt=1 and stall=0; the other controls are ignored that cycle.
- HALT->RUN on resume=1.
- RUN->FAULT on overflow or underflow. FAULT exits only via reset.
- RUN priority when stall=0 (highest first):
  - ret: pc<=stack_top, stack_pop=1, depth-=1.
  - call: pc<=target, stack_push=1, stack_in=pc+1, depth+=1.
  - jmp or br_taken: pc<=target.
  - else: pc<=pc+1.
- call and ret in the same cycle: ret wins, call is dropped, no push.
- stack_push and stack_pop are combinational and never both 1. Both are forced to 0 outside RUN or when stall=1.
- stall=1: pc, depth and state hold. halt is not sampled.
- Arithmetic: pc+1 and stack_in wrap modulo 2^PC_WIDTH, so 9'h1FF+1=9'h000.
- Overflow: call while depth==STACK_DEPTH. No push, pc holds, go to FAULT.
- Underflow: ret while depth==0. No pop, pc holds, go to FAULT.
- Latency: a control input sampled at edge N is visible on pc after edge N. The stack updates on the same edge.

Optional Feature:
- Macro: PC_SEQ_FAULT_VECTOR_EN.
- Defined:
  - Overflow/underflow sets fault=1 (sticky until reset), loads pc<=FAULT_VECTOR and depth<=0, and stays in RUN.
  - The offending push/pop is still suppressed.
- Undefined: FAULT state behaviour exactly as above; the FAULT_VECTOR parameter is unused.

Test Plan:
- Reset release, no controls -> pc_valid=0 for 1 cycle at pc=0, then pc=0,1,2,3 on successive cycles; rst_n low mid-run -> pc=0 and pc_valid=0 immediately, without waiting for a clock.
- pc=9'h010, call target=9'h080 -> stack_push=1, stack_in=9'h011, next pc=9'h080, depth=1; then ret with stack_top=9'h011 -> stack_pop=1, next pc=9'h011, depth=0.
- Two nested calls (depth=2), then a third call -> no push, fault=1, pc holds, pc_valid=0. With PC_SEQ_FAULT_VECTOR_EN: pc=9'h1F0, depth=0, pc_valid=1.
- depth=0, ret -> stack_pop=0, fault=1.
- call and ret together at depth=1 -> only pop, depth=0.
- pc=9'h1FF free-running -> next pc=9'h000. call at pc=9'h1FF -> stack_in=9'h000.
- stall=1 together with call -> stack_push=0, pc and depth unchanged. halt then resume -> pc held and pc_valid=0 during HALT, then resumes incrementing from the held value.
